// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST controller.
//   - bist_state_e : controller FSM states
//   - bist_mode_e  : test-pattern select encodings
//   - checkerboard bit pairs and the error-counter ceiling
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } bist_state_e;

  typedef enum logic [1:0] {
    ModeAddr    = 2'd0,  // data = address, zero-extended or truncated
    ModeAddrInv = 2'd1,  // data = ~address
    ModeChecker = 2'd2,  // 0xAAAA.. on even addresses, 0x5555.. on odd
    ModeOnes    = 2'd3   // data = all ones
  } bist_mode_e;

  // Two-bit seeds that are replicated across the word: bit i takes seed[i % 2].
  localparam logic [1:0] CheckerEvenPair = 2'b10;  // ...1010 -> 0xAAAA
  localparam logic [1:0] CheckerOddPair  = 2'b01;  // ...0101 -> 0x5555

  localparam logic [15:0] ErrCountMax = 16'hFFFF;

endpackage

// File: rtl/mem_bist_if.sv
// Bundle of the BIST host handshake and the memory port.
//   master : the BIST controller (drives memory address/data/enables and status)
//   slave  : host + memory side (drives start/mode and the memory read data)
interface mem_bist_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);

  // Host control / status
  logic                  start;
  logic [1:0]            mode;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [15:0]           err_count;
  logic [ADDR_WIDTH-1:0] first_err_addr;

  // Memory port
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_ena;
  logic                  read_ena;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  start, mode, data_out,
    output address, data_in, write_ena, read_ena,
    output busy, done, pass, err_count, first_err_addr
  );

  modport slave (
    output start, mode, data_out,
    input  address, data_in, write_ena, read_ena,
    input  busy, done, pass, err_count, first_err_addr
  );

endinterface

// File: rtl/mem_bist_rdpipe.sv
// RD_LAT-deep shift register that carries each read's {valid, expected data,
// address} alongside the memory access so it reaches the compare stage in the
// same cycle as the memory's read data.
//   clk_i, rst_i            : clock, synchronous active-high reset (clears all stages)
//   valid_i/exp_data_i/addr_i : read issued this cycle and what it should return
//   valid_o/exp_data_o/addr_o : same tuple, RD_LAT cycles later
module mem_bist_rdpipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] exp_data_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int unsigned StageW = 1 + DATA_WIDTH + ADDR_WIDTH;

  logic [StageW-1:0] stage_q [RD_LAT];

  // Reset clears every stage so compares in flight are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= {valid_i, exp_data_i, addr_i};
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign {valid_o, exp_data_o, addr_o} = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes a pattern to addresses 0..DEPTH-1, reads them
// back, compares each word RD_LAT cycles after its read and reports the result.
//   clk_i   : rising-edge clock
//   rst_i   : synchronous active-high reset; aborts a run and zeroes all outputs
//   bist_io : master side of mem_bist_if
//             start/mode in, data_out in (memory read data)
//             address/data_in/write_ena/read_ena out (memory port)
//             busy/done/pass/err_count/first_err_addr out (status)
// Done rises 2*DEPTH+RD_LAT edges after the edge that accepts start.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1
) (
  input logic       clk_i,
  input logic       rst_i,
  mem_bist_if.master bist_io
);

  localparam int unsigned DrainW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DrainW-1:0]     LastDrain = DrainW'(RD_LAT - 1);

  function automatic logic [DATA_WIDTH-1:0] pattern(bist_mode_e m, logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] pat;
    pat = '0;
    unique case (m)
      ModeAddr:    pat = DATA_WIDTH'(a);
      ModeAddrInv: pat = ~DATA_WIDTH'(a);
      ModeChecker: begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          pat[i] = a[0] ? CheckerOddPair[i[0]] : CheckerEvenPair[i[0]];
        end
      end
      ModeOnes:    pat = '1;
      default:     pat = '0;
    endcase
    return pat;
  endfunction

  bist_state_e           state_q;
  bist_mode_e            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DrainW-1:0]     drain_q;
  logic                  we_q;
  logic                  re_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;

  logic                  start_ok;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  // Start is only honoured when no run is active.
  assign start_ok = bist_io.start && ((state_q == StIdle) || (state_q == StDone));

  // ---------------------------------------------------------------------------
  // Controller FSM with registered memory-port and status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mode_q    <= ModeAddr;
      addr_q    <= '0;
      drain_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q   <= StWrite;
            mode_q    <= bist_mode_e'(bist_io.mode);
            addr_q    <= '0;
            we_q      <= 1'b1;
            data_in_q <= pattern(bist_mode_e'(bist_io.mode), '0);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        StWrite: begin
          if (addr_q == LastAddr) begin
            state_q   <= StRead;
            addr_q    <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b1;
            data_in_q <= '0;
          end else begin
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            data_in_q <= pattern(mode_q, addr_q + ADDR_WIDTH'(1));
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            state_q <= StDrain;
            addr_q  <= '0;
            re_q    <= 1'b0;
            drain_q <= '0;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          if (drain_q == LastDrain) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // The final compare lands on this same edge, so look at the next count.
            pass_q  <= (err_count_d == '0);
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-data pipeline and compare
  // ---------------------------------------------------------------------------
  assign rd_exp = pattern(mode_q, addr_q);

  mem_bist_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rdpipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (re_q),
    .exp_data_i (rd_exp),
    .addr_i     (addr_q),
    .valid_o    (cmp_valid),
    .exp_data_o (cmp_exp),
    .addr_o     (cmp_addr)
  );

  always_comb begin
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if (start_ok) begin
      err_count_d = '0;
      first_err_d = '0;
    end else if (cmp_valid && (bist_io.data_out != cmp_exp)) begin
      // Count never returns to zero within a run, so zero marks the first miss.
      if (err_count_q == '0) begin
        first_err_d = cmp_addr;
      end
      if (err_count_q != ErrCountMax) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign bist_io.address        = addr_q;
  assign bist_io.data_in        = data_in_q;
  assign bist_io.write_ena      = we_q;
  assign bist_io.read_ena       = re_q;
  assign bist_io.busy           = busy_q;
  assign bist_io.done           = done_q;
  assign bist_io.pass           = pass_q;
  assign bist_io.err_count      = err_count_q;
  assign bist_io.first_err_addr = first_err_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a behavioural memory with per-address fault masks,
// expectations derived directly from the pattern rules and the run timing.
module tb_mem_bist_ctrl;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 16;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned IW     = 10;
  localparam int          RunLat = 2 * DEPTH + RD_LAT;

  logic clk = 1'b0;
  logic rst;

  mem_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_bist_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bist_io (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read value = (stored | or_m) ^ xor_m, returned RD_LAT cycles later.
  logic [15:0] mem   [DEPTH];
  logic [15:0] or_m  [DEPTH];
  logic [15:0] xor_m [DEPTH];
  logic [15:0] rdp   [RD_LAT];

  always @(posedge clk) begin
    if (bus.write_ena && (bus.address < DEPTH)) mem[bus.address[IW-1:0]] <= bus.data_in;
    if (bus.read_ena && (bus.address < DEPTH))
      rdp[0] <= (mem[bus.address[IW-1:0]] | or_m[bus.address[IW-1:0]])
                ^ xor_m[bus.address[IW-1:0]];
    else
      rdp[0] <= 16'h0;
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end

  assign bus.data_out = rdp[RD_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input int a);
    logic [15:0] r;
    case (m)
      2'd0:    r = a[15:0];
      2'd1:    r = ~a[15:0];
      2'd2:    r = (a % 2 == 0) ? 16'hAAAA : 16'h5555;
      default: r = 16'hFFFF;
    endcase
    return r;
  endfunction

  // Bus observation, sampled 1 time unit after each rising edge.
  logic [1:0]  cur_mode;
  int          wr_n, wr_bad, rd_n, rd_bad, both_n;
  logic [15:0] wr_first [2];

  task automatic clear_obs();
    wr_n = 0; wr_bad = 0; rd_n = 0; rd_bad = 0; both_n = 0;
    wr_first[0] = 16'h0; wr_first[1] = 16'h0;
  endtask

  task automatic observe();
    if (bus.write_ena && bus.read_ena) both_n++;
    if (bus.write_ena) begin
      if (wr_n < 2) wr_first[wr_n] = bus.data_in;
      if ((int'(bus.address) != wr_n) || (bus.data_in != exp_pat(cur_mode, wr_n))) wr_bad++;
      wr_n++;
    end
    if (bus.read_ena) begin
      if (int'(bus.address) != rd_n) rd_bad++;
      rd_n++;
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      or_m[a]  = 16'h0;
      xor_m[a] = 16'h0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ":address"}, bus.address, 0);
    check_eq({tag, ":data_in"}, bus.data_in, 0);
    check_eq({tag, ":write_ena"}, bus.write_ena, 0);
    check_eq({tag, ":read_ena"}, bus.read_ena, 0);
    check_eq({tag, ":busy"}, bus.busy, 0);
    check_eq({tag, ":done"}, bus.done, 0);
    check_eq({tag, ":pass"}, bus.pass, 0);
    check_eq({tag, ":err_count"}, bus.err_count, 0);
    check_eq({tag, ":first_err"}, bus.first_err_addr, 0);
  endtask

  // Accept a start on the next edge; returns after that edge (+1).
  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = 2'($urandom);
  endtask

  // Full run; pulse_at > 0 raises start before that edge count (must fall while busy).
  task automatic run_test(input logic [1:0] m, input int pulse_at, input string tag);
    int          exp_err, exp_first, edges;
    logic [15:0] pv, rv;
    bit          seen;
    exp_err = 0;
    exp_first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      pv = exp_pat(m, a);
      rv = (pv | or_m[a]) ^ xor_m[a];
      if (rv != pv) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < 65535) exp_err++;
      end
    end
    cur_mode = m;
    clear_obs();
    do_start(m);
    check_eq({tag, ":busy_on_start"}, bus.busy, 1);
    check_eq({tag, ":done_clr"}, bus.done, 0);
    check_eq({tag, ":err_clr"}, bus.err_count, 0);
    observe();
    edges = 0;
    seen = 0;
    while (!seen && edges < RunLat + 20) begin
      bus.start = (edges + 1 == pulse_at);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges++;
      observe();
      if (bus.done) seen = 1;
    end
    check_eq({tag, ":latency"}, edges, RunLat);
    check_eq({tag, ":pass"}, bus.pass, (exp_err == 0));
    check_eq({tag, ":err_count"}, bus.err_count, exp_err);
    check_eq({tag, ":first_err"}, bus.first_err_addr, exp_first);
    check_eq({tag, ":busy_done"}, bus.busy, 0);
    check_eq({tag, ":addr_idle"}, bus.address, 0);
    check_eq({tag, ":wr_count"}, wr_n, DEPTH);
    check_eq({tag, ":wr_bad"}, wr_bad, 0);
    check_eq({tag, ":rd_count"}, rd_n, DEPTH);
    check_eq({tag, ":rd_bad"}, rd_bad, 0);
    check_eq({tag, ":we_re_overlap"}, both_n, 0);
  endtask

  initial begin
    int nf, a;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'd0;
    cur_mode = 2'd0;
    clear_obs();
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_test(2'd0, -1, "m0_good");

    run_test(2'd2, -1, "m2_good");
    check_eq("m2_wr_addr0", wr_first[0], 16'hAAAA);
    check_eq("m2_wr_addr1", wr_first[1], 16'h5555);

    or_m[5] = 16'h0008;
    run_test(2'd0, -1, "stuck_b3");
    clear_faults();

    run_test(2'd1, 50, "m1_pulse_wr");
    run_test(2'd3, DEPTH + 10, "m3_pulse_rd");

    for (int i = 0; i < DEPTH; i++) xor_m[i] = 16'hFFFF;
    run_test(2'd0, -1, "inverse");

    // Reset while compares are in flight: the queued mismatches must vanish.
    cur_mode = 2'd0;
    clear_obs();
    do_start(2'd0);
    repeat (DEPTH + 5) @(posedge clk);
    #1;
    check_eq("inflight:pre_err", bus.err_count, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("inflight:err_rst", bus.err_count, 0);
    repeat (RD_LAT + 5) @(posedge clk);
    #1;
    check_eq("inflight:err_after", bus.err_count, 0);
    check_eq("inflight:first_after", bus.first_err_addr, 0);
    clear_faults();

    // Start together with reset is ignored.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    clear_obs();
    repeat (4) begin
      @(posedge clk);
      #1;
      observe();
    end
    check_eq("start_rst:busy", bus.busy, 0);
    check_eq("start_rst:writes", wr_n, 0);

    // Reset at write cycle 100.
    cur_mode = 2'd0;
    clear_obs();
    do_start(2'd0);
    repeat (100) @(posedge clk);
    #1;
    check_eq("mid_rst:addr_pre", bus.address, 100);
    check_eq("mid_rst:we_pre", bus.write_ena, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("mid_rst");
    clear_obs();
    repeat (2 * RD_LAT + 10) begin
      @(posedge clk);
      #1;
      observe();
    end
    check_eq("mid_rst:no_wr", wr_n, 0);
    check_eq("mid_rst:no_rd", rd_n, 0);
    run_test(2'd0, -1, "post_rst");

    // Randomized fault sets, modes and ignored start pulses.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++) begin
        a = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) xor_m[a] = 16'($urandom);
        else or_m[a] = 16'($urandom);
      end
      run_test(2'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 2 * DEPTH) : -1,
               $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
